// File: rtl/stepper_pkg.sv
// Shared types and constants for the four-phase microstepping stepper driver.
package stepper_pkg;

    typedef enum logic [1:0] {
        ModeWave  = 2'd0,
        ModeFull  = 2'd1,
        ModeMicro = 2'd2
    } mode_t;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    // Phase index p names the leading coil pair.
    localparam logic [1:0] PH_AB = 2'd0;
    localparam logic [1:0] PH_BC = 2'd1;
    localparam logic [1:0] PH_CD = 2'd2;
    localparam logic [1:0] PH_DA = 2'd3;

    // Reserved encoding 3 drives like full-step.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'd0:    m = ModeWave;
            2'd2:    m = ModeMicro;
            default: m = ModeFull;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stepper_phase_map.sv
// Combinational mapping from phase, microstep index, mode and direction to four coil duty words.
module stepper_phase_map
    import stepper_pkg::*;
#(
    parameter int unsigned DUTY_W  = 8,
    parameter int unsigned MICRO_N = 8
) (
    input  logic [1:0]                      p_i,
    input  logic [$clog2(MICRO_N)-1:0]      k_i,
    input  mode_t                           mode_i,
    input  logic                            dir_i,
    input  logic                            energise_i,
    output logic [3:0][DUTY_W-1:0]          duty_o
);

    localparam int unsigned KW = $clog2(MICRO_N);
    localparam int unsigned PW = DUTY_W + 6;
    localparam logic [DUTY_W-1:0] DMAX = {DUTY_W{1'b1}};

    logic [PW-1:0]     prod;
    logic [DUTY_W-1:0] lead;
    logic [DUTY_W-1:0] trail;
    logic [DUTY_W-1:0] c0_val;
    logic [DUTY_W-1:0] c1_val;
    logic [1:0]        c1_idx;

    always_comb begin
        prod   = PW'(k_i) * PW'(DMAX);
        lead   = DUTY_W'(prod >> KW);
        trail  = DMAX - lead;
        c1_idx = p_i + 2'd1;
        c0_val = '0;
        c1_val = '0;
        case (mode_i)
            ModeWave: begin
                c0_val = DMAX;
            end
            ModeMicro: begin
                // Current migrates from coil p toward coil p+1 in the forward direction.
                if (dir_i) begin
                    c0_val = trail;
                    c1_val = lead;
                end else begin
                    c0_val = lead;
                    c1_val = trail;
                end
            end
            default: begin
                c0_val = DMAX;
                c1_val = DMAX;
            end
        endcase
        duty_o = '0;
        if (energise_i) begin
            duty_o[p_i]    = c0_val;
            duty_o[c1_idx] = c1_val;
        end
    end

endmodule

// File: rtl/stepper_microstep_ctrl.sv
// Four-phase stepper move controller: wave/full/microstep sequencing, position tracking and
// start/busy/done handshake with abort.
module stepper_microstep_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned DUTY_W  = 8,
    parameter int unsigned MICRO_N = 8,
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned DWELL_W = 12,
    parameter int unsigned POS_W   = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     dir_i,
    input  logic [1:0]               mode_i,
    input  logic [STEP_W-1:0]        steps_i,
    input  logic [DWELL_W-1:0]       dwell_i,
    input  logic                     abort_i,
    input  logic                     hold_en_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DUTY_W-1:0]        out_a_o,
    output logic [DUTY_W-1:0]        out_b_o,
    output logic [DUTY_W-1:0]        out_c_o,
    output logic [DUTY_W-1:0]        out_d_o,
    output logic signed [POS_W-1:0]  pos_o
);

    localparam int unsigned KW = $clog2(MICRO_N);
    localparam logic [KW-1:0] KLAST = KW'(MICRO_N - 1);

    state_t                  state_q, state_d;
    logic [1:0]              p_q, p_d;
    logic [KW-1:0]           k_q, k_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [STEP_W-1:0]       steps_q, steps_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [DWELL_W-1:0]      cnt_q, cnt_d;
    mode_t                   mode_q, mode_d;
    logic                    dir_q, dir_d;
    logic                    done_q, done_d;
    logic [3:0][DUTY_W-1:0]  out_q, out_d;

    logic                    step_done;
    logic                    energise;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        k_d       = k_q;
        pos_d     = pos_q;
        steps_d   = steps_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        step_done = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (steps_i != '0) begin
                        state_d = StRun;
                        mode_d  = decode_mode(mode_i);
                        dir_d   = dir_i;
                        steps_d = steps_i;
                        dwell_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                        cnt_d   = '0;
                        k_d     = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort takes priority, so a step finishing on the same edge is dropped.
                if (abort_i) begin
                    state_d = StIdle;
                    k_d     = '0;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
                    cnt_d = '0;
                    if (mode_q == ModeMicro) begin
                        k_d       = k_q + KW'(1);
                        step_done = (k_q == KLAST);
                    end else begin
                        step_done = 1'b1;
                    end
                    if (step_done) begin
                        p_d     = dir_q ? p_q + 2'd1 : p_q - 2'd1;
                        pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        steps_d = steps_q - STEP_W'(1);
                        if (steps_q == STEP_W'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        energise = (state_d == StRun) || hold_en_i;
    end

    // Duty words are computed from next-state values so they change on the same edge as p/k.
    stepper_phase_map #(
        .DUTY_W  (DUTY_W),
        .MICRO_N (MICRO_N)
    ) u_phase_map (
        .p_i        (p_d),
        .k_i        (k_d),
        .mode_i     (mode_d),
        .dir_i      (dir_d),
        .energise_i (energise),
        .duty_o     (out_d)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            p_q     <= PH_AB;
            k_q     <= '0;
            pos_q   <= '0;
            steps_q <= '0;
            dwell_q <= DWELL_W'(1);
            cnt_q   <= '0;
            mode_q  <= ModeFull;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            pos_q   <= pos_d;
            steps_q <= steps_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy_o  = (state_q == StRun);
    assign done_o  = done_q;
    assign out_a_o = out_q[0];
    assign out_b_o = out_q[1];
    assign out_c_o = out_q[2];
    assign out_d_o = out_q[3];
    assign pos_o   = pos_q;

endmodule

// File: tb/tb_stepper_microstep_ctrl.sv
// Randomized self-checking bench for stepper_microstep_ctrl against a per-move trace model.
module tb_stepper_microstep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] steps;
    logic [11:0] dwell;
    logic        abort;
    logic        hold_en;

    logic        busy, done;
    logic [7:0]  out_a, out_b, out_c, out_d;
    logic [23:0] pos;

    logic        busy4, done4;
    logic [7:0]  out4_a, out4_b, out4_c, out4_d;
    logic [3:0]  pos4;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of persistent state.
    int m_p, m_pos, m_mode, m_dir;

    always #5 clk = ~clk;

    stepper_microstep_ctrl u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .dir_i     (dir),
        .mode_i    (mode),
        .steps_i   (steps),
        .dwell_i   (dwell),
        .abort_i   (abort),
        .hold_en_i (hold_en),
        .busy_o    (busy),
        .done_o    (done),
        .out_a_o   (out_a),
        .out_b_o   (out_b),
        .out_c_o   (out_c),
        .out_d_o   (out_d),
        .pos_o     (pos)
    );

    // Narrow position counter to exercise two's-complement wrap.
    stepper_microstep_ctrl #(
        .POS_W (4)
    ) u_dut_pos4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .dir_i     (dir),
        .mode_i    (mode),
        .steps_i   (steps),
        .dwell_i   (dwell),
        .abort_i   (abort),
        .hold_en_i (hold_en),
        .busy_o    (busy4),
        .done_o    (done4),
        .out_a_o   (out4_a),
        .out_b_o   (out4_b),
        .out_c_o   (out4_c),
        .out_d_o   (out4_d),
        .pos_o     (pos4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int wrap4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    // Expected {A,B,C,D} for phase p, microstep k (of 8), mode and direction.
    function automatic logic [31:0] coils(input int p, input int k, input int md, input int dr,
                                          input bit en);
        int d[4];
        int lead, trail, c1;
        for (int i = 0; i < 4; i++) d[i] = 0;
        c1    = (p + 1) % 4;
        lead  = (k * 255) / 8;
        trail = 255 - lead;
        if (en) begin
            if (md == 0) begin
                d[p] = 255;
            end else if (md == 2) begin
                d[p]  = dr ? trail : lead;
                d[c1] = dr ? lead : trail;
            end else begin
                d[p]  = 255;
                d[c1] = 255;
            end
        end
        return {8'(d[0]), 8'(d[1]), 8'(d[2]), 8'(d[3])};
    endfunction

    function automatic logic [31:0] idle_coils();
        return coils(m_p, 0, m_mode, m_dir, hold_en);
    endfunction

    task automatic check_pos(input string tag, input int exp_pos);
        check_eq(tag, {8'h0, pos}, exp_pos & 32'h00FF_FFFF);
        check_eq({tag, "4"}, {28'h0, pos4}, exp_pos & 32'h0000_000F);
    endtask

    // One move from IDLE; ab_at < 0 means no abort, else abort during RUN cycle ab_at.
    task automatic run_move(input int md_raw, input int dr, input int st, input int dw_raw,
                            input bit hold, input int ab_at);
        int em, dw, kn, total, t, m, s, sg, s_final;
        bit aborted;
        em      = (md_raw == 0) ? 0 : (md_raw == 2) ? 2 : 1;
        dw      = (dw_raw == 0) ? 1 : dw_raw;
        kn      = (em == 2) ? 8 : 1;
        total   = st * kn * dw;
        aborted = 1'b0;
        start   = 1'b1;
        mode    = 2'(md_raw);
        dir     = 1'(dr);
        steps   = 16'(st);
        dwell   = 12'(dw_raw);
        hold_en = hold;
        abort   = 1'b0;
        @(posedge clk); #1;
        if (st == 0) begin
            check_eq("zero_done", {31'h0, done}, 1);
            check_eq("zero_busy", {31'h0, busy}, 0);
            check_eq("zero_coils", {out_a, out_b, out_c, out_d}, idle_coils());
            check_pos("zero_pos", m_pos);
            start = 1'b0;
            @(posedge clk); #1;
            check_eq("zero_done_clr", {31'h0, done}, 0);
            check_eq("zero_busy_clr", {31'h0, busy}, 0);
            return;
        end
        m_mode = em;
        m_dir  = dr;
        sg     = dr ? 1 : -1;
        t      = 0;
        while (1) begin
            m = t / dw;
            s = m / kn;
            check_eq("run_busy", {31'h0, busy}, 1);
            check_eq("run_done", {31'h0, done}, 0);
            check_eq("run_coils", {out_a, out_b, out_c, out_d},
                     coils(wrap4(m_p + sg * s), m % kn, em, dr, 1'b1));
            check_pos("run_pos", m_pos + sg * s);
            // Everything except abort must be ignored while running.
            start = 1'($urandom);
            mode  = 2'($urandom);
            dir   = 1'($urandom);
            steps = 16'($urandom);
            dwell = 12'($urandom);
            if (t == ab_at) abort = 1'b1;
            @(posedge clk); #1;
            if (t == ab_at) begin
                aborted = 1'b1;
                break;
            end
            t++;
            if (t == total) break;
        end
        abort   = 1'b0;
        start   = 1'b0;
        s_final = aborted ? (ab_at / dw) / kn : st;
        m_p     = wrap4(m_p + sg * s_final);
        m_pos   = m_pos + sg * s_final;
        check_eq("end_busy", {31'h0, busy}, 0);
        check_eq("end_done", {31'h0, done}, aborted ? 0 : 1);
        check_eq("end_coils", {out_a, out_b, out_c, out_d}, idle_coils());
        check_pos("end_pos", m_pos);
        @(posedge clk); #1;
        check_eq("post_done", {31'h0, done}, 0);
        check_eq("post_busy", {31'h0, busy}, 0);
        check_eq("post_coils", {out_a, out_b, out_c, out_d}, idle_coils());
    endtask

    task automatic model_reset();
        m_p    = 0;
        m_pos  = 0;
        m_mode = 1;
        m_dir  = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int md, dr, st, dw, kn, total, ab;
        rst     = 1'b1;
        start   = 1'b0;
        dir     = 1'b1;
        mode    = 2'd1;
        steps   = '0;
        dwell   = '0;
        abort   = 1'b0;
        hold_en = 1'b1;
        model_reset();
        #1;
        check_eq("rst_coils", {out_a, out_b, out_c, out_d}, 0);
        check_eq("rst_busy", {31'h0, busy}, 0);
        check_eq("rst_done", {31'h0, done}, 0);
        check_pos("rst_pos", 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_hold_ab", {out_a, out_b, out_c, out_d}, 32'hFFFF_0000);

        // Microstep forward, two steps, dwell 3.
        run_move(2, 1, 2, 3, 1'b1, -1);
        check_eq("micro_p2_pos2", {8'h0, pos}, 2);

        // Asynchronous reset in the middle of a move.
        start = 1'b1; mode = 2'd2; dir = 1'b1; steps = 16'd3; dwell = 12'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_coils", {out_a, out_b, out_c, out_d}, 0);
        check_eq("midrst_busy", {31'h0, busy}, 0);
        check_pos("midrst_pos", 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_idle", {out_a, out_b, out_c, out_d}, 32'hFFFF_0000);

        // Position wrap on the narrow counter: 7 then one more forward step.
        run_move(1, 1, 7, 1, 1'b1, -1);
        run_move(1, 1, 1, 1, 1'b1, -1);
        check_eq("pos4_wrap", {28'h0, pos4}, 32'h8);

        // Reverse wave, 5 steps of one clock from p=0.
        run_move(0, 0, 5, 1, 1'b1, -1);

        // Abort at cycle 10 of a 100-cycle wave move.
        run_move(0, 1, 10, 10, 1'b0, 10);

        // Edge inputs: zero steps, zero dwell, reserved mode, microstep abort.
        run_move(2, 0, 0, 2, 1'b1, -1);
        run_move(1, 0, 3, 0, 1'b1, -1);
        run_move(3, 1, 2, 2, 1'b1, -1);
        run_move(2, 0, 2, 1, 1'b1, 13);

        for (int i = 0; i < 40; i++) begin
            md    = int'($urandom_range(0, 3));
            dr    = int'($urandom_range(0, 1));
            st    = int'($urandom_range(0, 4));
            dw    = int'($urandom_range(0, 3));
            kn    = (md == 2) ? 8 : 1;
            total = st * kn * ((dw == 0) ? 1 : dw);
            ab    = -1;
            if (total > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, total - 1));
            run_move(md, dr, st, dw, 1'($urandom), ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
